fib_seq_ctrl: RTL

Sequencing controller for the hierarchical Fibonacci generator. It accepts a start command with a term count and steps the a/b term registers (a <= b, b <= a+b) once per accepted output beat. It emits F(0)..F(n) on a valid/ready stream and detects WIDTH-bit overflow. It sits between the host/testbench and the term-register datapath, and owns the state that the bare registers lack.

---
 rtl/fib_seq_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequencing controller: steps a/b term registers per accepted
// beat, streams F(0)..F(n) on valid/ready and flags WIDTH-bit overflow.
module fib_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic             abort,
  input  logic             out_ready,
  output logic [WIDTH-1:0] fib_out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] idx;
  logic [WIDTH-1:0] n_reg;
  logic             b_ovf;
  logic             ovf_q;

  logic             xfer;
  logic [WIDTH:0]   sum;

  // A beat moves only while streaming and the sink is ready.
  assign xfer = (state == RUN) && out_ready;

  // Extra bit of the next-term sum is the overflow carry.
  assign sum = {1'b0, a} + {1'b0, b};

  // Sequencer state, term registers and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a     <= '0;
      b     <= WIDTH'(1);
      idx   <= '0;
      n_reg <= '0;
      b_ovf <= 1'b0;
      ovf_q <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      a     <= '0;
      b     <= WIDTH'(1);
      idx   <= '0;
      b_ovf <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            n_reg <= n;
            a     <= '0;
            b     <= WIDTH'(1);
            idx   <= '0;
            b_ovf <= 1'b0;
            ovf_q <= 1'b0;
          end
        end
        RUN: begin
          if (xfer) begin
            if (idx == n_reg) begin
              state <= DONE;
              ovf_q <= 1'b0;
            end else if (b_ovf) begin
              state <= DONE;
              ovf_q <= 1'b1;
            end else begin
              a     <= b;
              b     <= sum[WIDTH-1:0];
              b_ovf <= b_ovf | sum[WIDTH];
              idx   <= idx + WIDTH'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only.
  assign fib_out   = a;
  assign out_valid = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign overflow  = ovf_q;

endmodule
